// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter: two-requester round-robin arbiter driving an async SRAM.
// Each transaction walks IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> DONE.
// All SRAM strobes are decoded from registered state, so an asynchronous
// clear drops them at once without waiting for a clock edge.
module sram_arbiter #(
  parameter int unsigned AW       = 18,
  parameter int unsigned DW       = 16,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  input  logic [DW-1:0] sram_din,
  output logic          sram_drive,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  // A wait count of 0 would make ACCESS vanish; clamp it to one cycle.
  localparam int unsigned   WC_I    = (WAIT_CYC == 0) ? 1 : WAIT_CYC;
  localparam logic [3:0]    WC_LAST = 4'(WC_I - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  // gnt_q is both the current grant and the round-robin "last granted" flag.
  logic          gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pick;

  // State and transaction registers; clear forces the idle/reset image.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      gnt_q   <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitration, request latching, wait counting, read capture.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    pick    = req0 & req1 ? ~gnt_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          wr_d    = pick ? wr1    : wr0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == WC_LAST) begin
          state_d = DONE;
          if (!wr_q) rdata_d = sram_din;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode; drive and oe_n are mutually exclusive because both key off wr_q.
  always_comb begin
    busy       = (state_q != IDLE);
    sram_ce_n  = (state_q == IDLE);
    sram_oe_n  = !(!wr_q && (state_q == SETUP || state_q == ACCESS));
    sram_we_n  = !(wr_q && state_q == ACCESS);
    sram_drive = wr_q && (state_q != IDLE);
    ack0       = (state_q == DONE) && !gnt_q;
    ack1       = (state_q == DONE) && gnt_q;
    sram_addr  = addr_q;
    sram_dout  = wdata_q;
    rdata      = rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for sram_arbiter (default parameters, WAIT_CYC=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata, sram_dout, sram_din;
  logic [AW-1:0] sram_addr;
  logic          sram_drive, sram_ce_n, sram_oe_n, sram_we_n;

  int errs = 0;
  int checks = 0;

  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(2)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    clr = 1'b1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; sram_din = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, ack0, ack1, sram_ce_n, sram_oe_n, sram_we_n, sram_drive} !== 7'b0001110) begin
      errs++;
      $display("FAIL reset_strobes got=%b exp=0001110",
               {busy, ack0, ack1, sram_ce_n, sram_oe_n, sram_we_n, sram_drive});
    end
    checks++;
    if ({sram_addr, sram_dout, rdata} !== '0) begin
      errs++;
      $display("FAIL reset_data addr=%h dout=%h rdata=%h exp all 0", sram_addr, sram_dout, rdata);
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle busy=%b exp=0", busy); end
  endtask

  // Write by requester 0; addr0 is changed right after the grant.
  task automatic test_write();
    int we_lo = 0, ack_at = 0, ack_n = 0, ack1_n = 0;
    bit drv_ok = 1, addr_ok = 1, oe_seen = 0;
    req0 = 1; wr0 = 1; addr0 = 18'h00010; wdata0 = 16'hA5A5;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({busy, sram_ce_n, sram_oe_n, sram_we_n, sram_drive} !== 5'b10111) begin
          errs++;
          $display("FAIL wr_setup got=%b exp=10111", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_drive});
        end
        req0 = 0; addr0 = 18'h3FFFF;
      end
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_seen = 1;
      if (ack0) begin ack_n++; ack_at = k; end
      if (ack1) ack1_n++;
      if (k <= 4) begin
        if (sram_drive !== 1'b1) drv_ok = 0;
        if (sram_addr !== 18'h00010) addr_ok = 0;
      end
      if (k == 4) begin
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b011) begin
          errs++; $display("FAIL wr_done_strobes got=%b exp=011", {sram_ce_n, sram_oe_n, sram_we_n});
        end
      end
      if (k == 5) begin
        checks++;
        if ({busy, sram_ce_n, sram_oe_n, sram_we_n, sram_drive} !== 5'b01110) begin
          errs++;
          $display("FAIL wr_idle got=%b exp=01110", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_drive});
        end
        checks++;
        if (sram_addr !== 18'h00010 || sram_dout !== 16'hA5A5) begin
          errs++; $display("FAIL wr_idle_hold addr=%h dout=%h exp=00010/a5a5", sram_addr, sram_dout);
        end
      end
    end
    checks++; if (we_lo !== 2) begin errs++; $display("FAIL wr_we_cycles got=%0d exp=2", we_lo); end
    checks++; if (ack_at !== 4 || ack_n !== 1) begin errs++; $display("FAIL wr_ack0 at=%0d n=%0d exp at=4 n=1", ack_at, ack_n); end
    checks++; if (ack1_n !== 0) begin errs++; $display("FAIL wr_no_ack1 got=%0d exp=0", ack1_n); end
    checks++; if (!drv_ok) begin errs++; $display("FAIL wr_drive got=0 exp=1 from SETUP to DONE"); end
    checks++; if (!addr_ok) begin errs++; $display("FAIL wr_addr_latched got=changed exp=00010"); end
    checks++; if (oe_seen) begin errs++; $display("FAIL wr_oe got=low exp=high during write"); end
  endtask

  // Read by requester 1 from a constant SRAM model.
  task automatic test_read();
    int oe_lo = 0, ack_at = 0;
    bit drv_seen = 0;
    logic [DW-1:0] rd_at_ack = '0;
    sram_din = 16'hA5A5;
    req1 = 1; wr1 = 0; addr1 = 18'h00010;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req1 = 0;
      if (sram_drive) drv_seen = 1;
      if (!sram_oe_n) oe_lo++;
      if (ack1) begin ack_at = k; rd_at_ack = rdata; end
      if (k == 3) begin
        checks++;
        if (rdata !== 16'h0000) begin errs++; $display("FAIL rd_early got=%h exp=0000", rdata); end
      end
    end
    checks++; if (ack_at !== 4) begin errs++; $display("FAIL rd_ack1_at got=%0d exp=4", ack_at); end
    checks++; if (rd_at_ack !== 16'hA5A5) begin errs++; $display("FAIL rd_data got=%h exp=a5a5", rd_at_ack); end
    checks++; if (drv_seen) begin errs++; $display("FAIL rd_drive got=1 exp=0"); end
    checks++; if (oe_lo !== 3) begin errs++; $display("FAIL rd_oe_cycles got=%0d exp=3", oe_lo); end
  endtask

  // Requester 1 write that drops req in ACCESS; rdata must be untouched.
  task automatic test_drop_req();
    int ack_n = 0, ack_at = 0, a0 = 0;
    sram_din = 16'h1234;
    req1 = 1; wr1 = 1; addr1 = 18'h00020; wdata1 = 16'h5A5A;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if ({busy, sram_we_n} !== 2'b10) begin errs++; $display("FAIL drop_access got=%b exp=10", {busy, sram_we_n}); end
        req1 = 0;
      end
      if (ack1) begin ack_n++; ack_at = k; end
      if (ack0) a0++;
      if (k == 5) begin
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL drop_idle busy=%b exp=0", busy); end
      end
    end
    checks++; if (ack_n !== 1 || ack_at !== 4) begin errs++; $display("FAIL drop_ack1 n=%0d at=%0d exp n=1 at=4", ack_n, ack_at); end
    checks++; if (a0 !== 0) begin errs++; $display("FAIL drop_no_ack0 got=%0d exp=0", a0); end
    checks++; if (rdata !== 16'hA5A5) begin errs++; $display("FAIL drop_rdata_kept got=%h exp=a5a5", rdata); end
  endtask

  // Both requesters held high from reset: alternating grants every 5 cycles.
  task automatic test_round_robin();
    int n = 0, overlap = 0;
    int ev_k[8];
    bit ev_who[8];
    int exp_k[4] = '{4, 9, 14, 19};
    @(negedge clk);
    clr = 1; req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 18'h00100; addr1 = 18'h00200;
    @(negedge clk);
    checks++;
    if (rdata !== 16'h0000 || busy !== 1'b0) begin
      errs++; $display("FAIL rr_clr rdata=%h busy=%b exp=0000/0", rdata, busy);
    end
    clr = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack0 && ack1) overlap++;
      if ((ack0 || ack1) && n < 8) begin ev_k[n] = k; ev_who[n] = ack1; n++; end
      if (k == 20) begin req0 = 0; req1 = 0; end
    end
    checks++; if (overlap !== 0) begin errs++; $display("FAIL rr_overlap got=%0d exp=0", overlap); end
    checks++;
    if (n !== 4) begin
      errs++; $display("FAIL rr_count got=%0d exp=4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev_k[i] !== exp_k[i] || ev_who[i] !== i[0]) begin
          errs++; $display("FAIL rr_ack%0d at=%0d who=%0d exp at=%0d who=%0d", i, ev_k[i], ev_who[i], exp_k[i], i[0]);
        end
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_idle busy=%b exp=0", busy); end
  endtask

  // Asynchronous clear during a write's ACCESS, then a normal read.
  task automatic test_clr_abort();
    int a0 = 0, ack_at = 0;
    logic [AW-1:0] addr_at = '0;
    logic [DW-1:0] rd_at = '0;
    sram_din = 16'h1234;
    req0 = 1; wr0 = 1; addr0 = 18'h00030; wdata0 = 16'h1111;
    @(negedge clk); req0 = 0;
    @(negedge clk);
    checks++;
    if ({busy, sram_we_n} !== 2'b10) begin errs++; $display("FAIL abort_pre got=%b exp=10", {busy, sram_we_n}); end
    #2 clr = 1;
    #1;
    checks++;
    if ({busy, sram_we_n, ack0, sram_drive, sram_ce_n} !== 5'b01001) begin
      errs++; $display("FAIL abort_async got=%b exp=01001", {busy, sram_we_n, ack0, sram_drive, sram_ce_n});
    end
    @(negedge clk); clr = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack0 || ack1) a0++;
    end
    checks++; if (a0 !== 0) begin errs++; $display("FAIL abort_no_ack got=%0d exp=0", a0); end
    req0 = 1; wr0 = 0; addr0 = 18'h00040;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req0 = 0;
      if (ack0) begin ack_at = k; addr_at = sram_addr; rd_at = rdata; end
    end
    checks++; if (ack_at !== 4) begin errs++; $display("FAIL abort_next_ack got=%0d exp=4", ack_at); end
    checks++;
    if (addr_at !== 18'h00040 || rd_at !== 16'h1234) begin
      errs++; $display("FAIL abort_next_rd addr=%h rdata=%h exp=00040/1234", addr_at, rd_at);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drop_req();
    test_round_robin();
    test_clr_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
